// File: rtl/seven_seg_scan.sv
// Time-multiplexed digit scanner feeding a nibble-to-segment decoder.
// Ports: clk, rst (sync, active-high); value_in/dp_in/load (pending value),
// lz_blank (leading-zero blanking); nibble_out/dp_out (registered decoder
// inputs), digit_en (digit commons), frame_tick (start-of-frame pulse).
module seven_seg_scan #(
    parameter int NUM_DIGITS       = 4,
    parameter int SCAN_DIV         = 12000,
    parameter int BLANK_CYCLES     = 16,
    parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   value_in,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic                      load,
    input  logic                      lz_blank,
    output logic [3:0]                nibble_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     digit_en,
    output logic                      frame_tick
);

    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int MAXC = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
    localparam logic [CW-1:0] ON_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BL_LAST  = CW'(BLANK_CYCLES - 1);

    typedef enum logic {
        BLANK,
        ON
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    init_q;
    logic [4*NUM_DIGITS-1:0] act_val, pend_val, nxt_val;
    logic [NUM_DIGITS-1:0]   act_dp, pend_dp, nxt_dp;
    logic                    lz_q;
    logic                    boundary, slot_end;
    logic [NUM_DIGITS-1:0]   blanked, en;
    logic                    hi_zero;

    // init_q marks the reset state; the first cycle after it is a frame
    // boundary, so the scan always starts from a freshly loaded value.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q + CW'(1);
        boundary = 1'b0;
        slot_end = 1'b0;
        if (init_q) begin
            boundary = 1'b1;
            state_d  = BLANK;
            idx_d    = '0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                BLANK: begin
                    if (cnt_q == BL_LAST) begin
                        state_d = ON;
                        cnt_d   = '0;
                    end
                end
                ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d  = BLANK;
                        cnt_d    = '0;
                        slot_end = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            idx_d    = '0;
                            boundary = 1'b1;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // A load coinciding with the boundary goes straight to the display.
    assign nxt_val = load ? value_in : pend_val;
    assign nxt_dp  = load ? dp_in    : pend_dp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BLANK;
            idx_q      <= '0;
            cnt_q      <= '0;
            init_q     <= 1'b1;
            act_val    <= '0;
            act_dp     <= '0;
            pend_val   <= '0;
            pend_dp    <= '0;
            lz_q       <= 1'b0;
            nibble_out <= 4'd0;
            dp_out     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            init_q     <= 1'b0;
            frame_tick <= boundary;
            if (load) begin
                pend_val <= value_in;
                pend_dp  <= dp_in;
            end
            if (boundary) begin
                act_val    <= nxt_val;
                act_dp     <= nxt_dp;
                lz_q       <= lz_blank;
                nibble_out <= nxt_val[3:0];
                dp_out     <= nxt_dp[0];
            end else if (frame_tick) begin
                // Load during the frame_tick cycle still lands in this
                // frame; digit 0 is in dead time, so the swap is invisible.
                lz_q <= lz_blank;
                if (load) begin
                    act_val    <= value_in;
                    act_dp     <= dp_in;
                    nibble_out <= value_in[3:0];
                    dp_out     <= dp_in[0];
                end
            end else if (slot_end) begin
                nibble_out <= act_val[{idx_d, 2'b00} +: 4];
                dp_out     <= act_dp[idx_d];
            end
        end
    end

    // Walk down from the top digit; a digit is a leading zero while every
    // nibble at or above it is zero. A set dp keeps the digit lit.
    always_comb begin
        blanked = '0;
        hi_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            hi_zero    = hi_zero && (act_val[4*k +: 4] == 4'd0);
            blanked[k] = lz_q && hi_zero && !act_dp[k];
        end
    end

    always_comb begin
        en = '0;
        if (state_q == ON && !blanked[idx_q]) begin
            en[idx_q] = 1'b1;
        end
    end

    assign digit_en = DIGIT_ACTIVE_LOW ? ~en : en;

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan (4 digits, 2 blank + 4 on cycles).
// Expected per-cycle outputs are queued from a frame model and popped each clock.
module tb_seven_seg_scan;

    localparam int ND = 4;
    localparam int FR = 24;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic        lz_blank = 1'b0;
    logic [3:0]  nibble_out;
    logic        dp_out;
    logic [3:0]  digit_en;
    logic        frame_tick;

    seven_seg_scan #(
        .NUM_DIGITS(ND),
        .SCAN_DIV(4),
        .BLANK_CYCLES(2),
        .DIGIT_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .value_in(value_in),
        .dp_in(dp_in),
        .load(load),
        .lz_blank(lz_blank),
        .nibble_out(nibble_out),
        .dp_out(dp_out),
        .digit_en(digit_en),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] en;
        logic [3:0] nib;
        logic       dp;
        logic       ft;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          fc = -1;
    logic [15:0] pend = '0;
    logic [15:0] act = '0;
    logic [3:0]  pend_dp = '0;
    logic [3:0]  act_dp = '0;
    logic        act_lz = 1'b0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s fc=%0d got %0h exp %0h", tag, fc, got, exp);
        end
    endtask

    task automatic push_frame(int from);
        logic [3:0] blk;
        exp_t       e;
        int         h;
        int         s;
        int         p;
        h = -1;
        for (int k = 0; k < ND; k++)
            if (act[4*k +: 4] != 4'd0) h = k;
        for (int k = 0; k < ND; k++)
            blk[k] = act_lz && (k > 0) && (k > h) && !act_dp[k];
        for (int c = from; c < FR; c++) begin
            s = c / 6;
            p = c % 6;
            e.en = 4'b1111;
            if (p >= 2 && !blk[s]) e.en[s] = 1'b0;
            e.nib = act[4*s +: 4];
            e.dp  = act_dp[s];
            e.ft  = (c == 0);
            q.push_back(e);
        end
    endtask

    task automatic step();
        int   nfc;
        exp_t e;
        nfc = (fc < 0) ? 0 : (fc + 1) % FR;
        if (rst) begin
            nfc = -1;
            q.delete();
            pend    = '0;
            pend_dp = '0;
            act     = '0;
            act_dp  = '0;
            e       = '{en: 4'b1111, nib: 4'd0, dp: 1'b0, ft: 1'b0};
            q.push_back(e);
        end else begin
            if (nfc == 0) begin
                act    = load ? value_in : pend;
                act_dp = load ? dp_in : pend_dp;
                act_lz = lz_blank;
                q.delete();
                push_frame(0);
            end else if (fc == 0) begin
                if (load) begin
                    act    = value_in;
                    act_dp = dp_in;
                end
                act_lz = lz_blank;
                q.delete();
                push_frame(1);
            end
            if (load) begin
                pend    = value_in;
                pend_dp = dp_in;
            end
        end
        @(posedge clk);
        #1;
        fc = nfc;
        if (q.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL q_empty fc=%0d", fc);
        end else begin
            e = q.pop_front();
            chk("digit_en", 32'(digit_en), 32'(e.en));
            chk("nibble", 32'(nibble_out), 32'(e.nib));
            chk("dp_out", 32'(dp_out), 32'(e.dp));
            chk("frame_tick", 32'(frame_tick), 32'(e.ft));
        end
    endtask

    task automatic run_to(int target);
        int guard;
        guard = 0;
        while (fc != target && guard < 2 * FR) begin
            step();
            guard++;
        end
        chk("run_to", 32'(fc), 32'(target));
    endtask

    task automatic pulse_load(logic [15:0] v, logic [3:0] d);
        value_in = v;
        dp_in    = d;
        load     = 1'b1;
        step();
        load     = 1'b0;
        dp_in    = '0;
    endtask

    initial begin
        // reset state held for two cycles
        step();
        step();
        rst = 1'b0;
        step();
        // frame 0 shows zeros; 1234 queued mid-frame
        run_to(5);
        pulse_load(16'h1234, 4'b0000);
        run_to(23);
        step();
        run_to(23);
        // tearing: load while digit 2 is lit
        step();
        run_to(15);
        pulse_load(16'hABCD, 4'b0000);
        run_to(23);
        step();
        run_to(23);
        // leading-zero blanking
        lz_blank = 1'b1;
        step();
        run_to(5);
        pulse_load(16'h0050, 4'b0000);
        run_to(23);
        step();
        run_to(5);
        pulse_load(16'h0000, 4'b0000);
        run_to(23);
        step();
        // dp keeps a zero digit lit
        run_to(5);
        pulse_load(16'h0007, 4'b0100);
        run_to(23);
        step();
        // load on the frame_tick cycle
        run_to(23);
        step();
        pulse_load(16'h9999, 4'b0000);
        run_to(23);
        step();
        // reset during digit 1 ON
        run_to(9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        run_to(23);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
